multisim_stream_downsizer: RTL and testbench
============================================

// Module: multisim_stream_downsizer
// PURPOSE
//  Width down-converter placed directly downstream of the multisim pull client. Takes one
//  IN_WIDTH word per vld/rdy handshake and emits it as RATIO = IN_WIDTH/OUT_WIDTH
//  OUT_WIDTH beats on a vld/rdy stream into the DUT, flagging the final beat of each word.
//  Fully registered; no combinational path from any input to out_vld or out_data.
// PARAMETERS
//  IN_WIDTH   64  width of the word from the pull client; must be a multiple of OUT_WIDTH
//  OUT_WIDTH  16  width of one output beat; RATIO = IN_WIDTH/OUT_WIDTH, RATIO>=1
// PORTS
//  clk       in   1          clock; all state updates on posedge
//  rst       in   1          asynchronous, active-high reset
//  in_vld    in   1          input word valid (connects to client data_vld)
//  in_rdy    out  1          input word accepted when in_vld && in_rdy (to client data_rdy)
//  in_data   in   IN_WIDTH   input word
//  out_vld   out  1          output beat valid
//  out_rdy   in   1          downstream ready; beat transfers when out_vld && out_rdy
//  out_data  out  OUT_WIDTH  current beat
//  out_last  out  1          high on the final beat (index RATIO-1) of a word
// BEHAVIOUR
//  - State: hold_q[IN_WIDTH-1:0], full_q, beat_q[$clog2(RATIO)] (1 bit when RATIO==1, held 0).
//  - Reset (async, while rst high): full_q=0, beat_q=0, hold_q=0 -> out_vld=0, out_last=0,
//    out_data=0; in_rdy=0 while rst high. Reset mid-word discards remaining beats.
//  - States: EMPTY (full_q=0) and SERVE (full_q=1). out_vld = full_q.
//  - out_data = hold_q[beat_q*OUT_WIDTH +: OUT_WIDTH]; beat 0 = bits [OUT_WIDTH-1:0] (LSB first).
//  - out_last = full_q && (beat_q == RATIO-1).
//  - in_rdy = !full_q || (out_rdy && out_last)  (bubble-free: new word loads on the same
//    edge the last beat leaves).
//  - Latency: word accepted at edge N -> beat 0 visible (out_vld=1) after edge N.
//  - EMPTY: on in_vld -> load hold_q=in_data, beat_q=0, go SERVE.
//  - SERVE, out_rdy=0: hold all state; out_data/out_last stable (AXI-style no-retract).
//  - SERVE, out_rdy=1, beat_q<RATIO-1: beat_q++.
//  - SERVE, out_rdy=1, last beat: if in_vld load new word, beat_q=0, stay SERVE;
//    else full_q=0, beat_q=0, go EMPTY.
//  - RATIO==1: degenerates to a single-entry registered pipe stage; out_last=out_vld.
//  - in_data ignored unless in_vld && in_rdy. Sustained throughput: 1 word per RATIO cycles.
//  - Elaboration error (fatal) if IN_WIDTH % OUT_WIDTH != 0 or OUT_WIDTH==0.
// CONFIGURATION
//  MULTISIM_DOWNSIZER_MSB_FIRST_EN
//   defined:   beat k = hold_q[(RATIO-1-k)*OUT_WIDTH +: OUT_WIDTH] (MSB slice first);
//              out_last, handshake and timing unchanged.
//   undefined: LSB-first order as above (default).
// TESTING  (IN_WIDTH=64, OUT_WIDTH=16, out_rdy=1 unless stated)
//  1 in_data=64'h4444_3333_2222_1111 one word -> beats 1111,2222,3333,4444 on 4 consecutive
//    cycles starting 1 cycle after accept; out_last only on 4444; out_vld low afterwards.
//  2 in_vld held high, words A,B back-to-back -> 8 contiguous beats, no bubble; in_rdy high
//    exactly on the cycle of each last beat (and first cycle from EMPTY).
//  3 out_rdy low 3 cycles during beat 2222 -> out_data=2222, out_vld=1 stable for 3 cycles,
//    in_rdy=0, no beat lost/duplicated; then 3333,4444 resume.
//  4 assert rst after beat 2222 -> out_vld/out_last/out_data=0 immediately (async), in_rdy=0;
//    after release next word starts at beat 0 with its own LSB slice.
//  5 MULTISIM_DOWNSIZER_MSB_FIRST_EN defined, word of test 1 -> 4444,3333,2222,1111,
//    out_last on 1111.
//  6 RATIO==1 (IN=OUT=64), random vld/rdy with upstream pull client model -> output
//    sequence equals input sequence, out_last==out_vld every beat, scoreboard clean.

Source files
------------

// File: rtl/multisim_stream_downsizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : multisim_stream_downsizer
//  Purpose  : Registered IN_WIDTH -> OUT_WIDTH vld/rdy width down-converter.
//             Define MULTISIM_DOWNSIZER_MSB_FIRST_EN for MSB-slice-first order.
//  Revision : 1.0 - initial release
// ============================================================================
module multisim_stream_downsizer #(
    parameter int IN_WIDTH  = 64,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_last
);

    localparam bit BAD_CFG = (OUT_WIDTH <= 0) ? 1'b1
                           : ((IN_WIDTH % OUT_WIDTH) != 0) || (IN_WIDTH < OUT_WIDTH);
    localparam int RATIO  = (OUT_WIDTH > 0) ? IN_WIDTH / OUT_WIDTH : 1;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    generate
        if (BAD_CFG) begin : g_bad_cfg
            $fatal(1, "IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
        end
    endgenerate

    typedef enum logic {
        EMPTY = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q,  beat_d;
    logic [IN_WIDTH-1:0]   hold_q,  hold_d;

    logic w_full;
    logic w_last;

    assign w_full   = (state_q == SERVE);
    assign w_last   = w_full && (beat_q == LAST_BEAT);
    assign out_vld  = w_full;
    assign out_last = w_last;
    // A new word may load on the same edge the last beat of the current word leaves.
    assign in_rdy   = !rst && (!w_full || (out_rdy && w_last));

    always_comb begin
        out_data = '0;
        for (int k = 0; k < RATIO; k++) begin
            if (beat_q == BEAT_W'(k)) begin
`ifdef MULTISIM_DOWNSIZER_MSB_FIRST_EN
                out_data = hold_q[(RATIO-1-k)*OUT_WIDTH +: OUT_WIDTH];
`else
                out_data = hold_q[k*OUT_WIDTH +: OUT_WIDTH];
`endif
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        hold_d  = hold_q;
        case (state_q)
            EMPTY: begin
                if (in_vld) begin
                    hold_d  = in_data;
                    beat_d  = '0;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (out_rdy) begin
                    if (beat_q != LAST_BEAT) begin
                        beat_d = beat_q + 1'b1;
                    end else if (in_vld) begin
                        hold_d = in_data;
                        beat_d = '0;
                    end else begin
                        beat_d  = '0;
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            beat_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            hold_q  <= hold_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multisim_stream_downsizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_multisim_stream_downsizer
//  Purpose  : Scoreboard bench for the 64->16 downsizer and a 64->64 instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multisim_stream_downsizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_vld, in_rdy, out_vld, out_rdy, out_last;
    logic [63:0] in_data;
    logic [15:0] out_data;
    logic        in1_vld, in1_rdy, out1_vld, out1_rdy, out1_last;
    logic [63:0] in1_data, out1_data;

    int errors = 0;
    int checks = 0;

    logic [16:0] exp_q[$];
    logic [16:0] obs_mem[0:511];
    int          obs_n = 0;

    always #5 clk = ~clk;

    multisim_stream_downsizer #(.IN_WIDTH(64), .OUT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last)
    );

    multisim_stream_downsizer #(.IN_WIDTH(64), .OUT_WIDTH(64)) dut1 (
        .clk(clk), .rst(rst),
        .in_vld(in1_vld), .in_rdy(in1_rdy), .in_data(in1_data),
        .out_vld(out1_vld), .out_rdy(out1_rdy), .out_data(out1_data), .out_last(out1_last)
    );

    // Record every beat that actually transfers on the narrow instance.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy && obs_n < 512) begin
            obs_mem[obs_n] <= {out_last, out_data};
            obs_n          <= obs_n + 1;
        end
    end

    function automatic logic [15:0] beat_of(input logic [63:0] w, input int k);
`ifdef MULTISIM_DOWNSIZER_MSB_FIRST_EN
        return w[(3-k)*16 +: 16];
`else
        return w[k*16 +: 16];
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b0; in_data = '0; out_rdy = 1'b1;
        in1_vld = 1'b0; in1_data = '0; out1_rdy = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b expected 0", out_vld); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy: got %b expected 0", in_rdy); end
        checks++; if (out1_vld !== 1'b0) begin errors++; $display("FAIL reset_out1_vld: got %b expected 0", out1_vld); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_release_in_rdy: got %b expected 1", in_rdy); end
    endtask

    task automatic test_single(input logic [63:0] w);
        @(posedge clk); #1;
        in_vld = 1'b1; in_data = w;
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), beat_of(w, k)});
        @(negedge clk);
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL single_in_rdy: got %b expected 1", in_rdy); end
        @(posedge clk); #1;
        in_vld = 1'b0; in_data = 64'hDEAD_BEEF_0BAD_F00D;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL single_vld[%0d]: got %b expected 1", k, out_vld); end
            checks++; if (out_data !== beat_of(w, k)) begin errors++; $display("FAIL single_data[%0d]: got %h expected %h", k, out_data, beat_of(w, k)); end
            checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL single_last[%0d]: got %b expected %b", k, out_last, (k == 3)); end
        end
        @(negedge clk);
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL single_idle_vld: got %b expected 0", out_vld); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL single_idle_last: got %b expected 0", out_last); end
    endtask

    task automatic test_back_to_back(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] w;
        @(posedge clk); #1;
        in_vld = 1'b1; in_data = a;
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), beat_of(a, k)});
        @(negedge clk);
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL b2b_first_in_rdy: got %b expected 1", in_rdy); end
        @(posedge clk); #1;
        in_data = b;
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), beat_of(b, k)});
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            w = (c < 4) ? a : b;
            checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL b2b_vld[%0d]: got %b expected 1", c, out_vld); end
            checks++; if (out_data !== beat_of(w, c % 4)) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", c, out_data, beat_of(w, c % 4)); end
            checks++; if (in_rdy !== (c == 3 || c == 7)) begin errors++; $display("FAIL b2b_in_rdy[%0d]: got %b expected %b", c, in_rdy, (c == 3 || c == 7)); end
            if (c == 3) begin
                @(posedge clk); #1 in_vld = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL b2b_idle_vld: got %b expected 0", out_vld); end
    endtask

    task automatic test_stall(input logic [63:0] w);
        @(posedge clk); #1;
        in_vld = 1'b1; in_data = w;
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), beat_of(w, k)});
        @(posedge clk); #1 in_vld = 1'b0;
        @(negedge clk);
        checks++; if (out_data !== beat_of(w, 0)) begin errors++; $display("FAIL stall_beat0: got %h expected %h", out_data, beat_of(w, 0)); end
        @(posedge clk); #1 out_rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL stall_vld[%0d]: got %b expected 1", s, out_vld); end
            checks++; if (out_data !== beat_of(w, 1)) begin errors++; $display("FAIL stall_data[%0d]: got %h expected %h", s, out_data, beat_of(w, 1)); end
            checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL stall_in_rdy[%0d]: got %b expected 0", s, in_rdy); end
            checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL stall_last[%0d]: got %b expected 0", s, out_last); end
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            checks++; if (out_data !== beat_of(w, k)) begin errors++; $display("FAIL stall_resume_data[%0d]: got %h expected %h", k, out_data, beat_of(w, k)); end
            checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL stall_resume_last[%0d]: got %b expected %b", k, out_last, (k == 3)); end
        end
        @(negedge clk);
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL stall_idle_vld: got %b expected 0", out_vld); end
    endtask

    task automatic test_reset_mid(input logic [63:0] w, input logic [63:0] w2);
        @(posedge clk); #1;
        in_vld = 1'b1; in_data = w;
        for (int k = 0; k < 2; k++) exp_q.push_back({1'b0, beat_of(w, k)});
        @(posedge clk); #1 in_vld = 1'b0;
        @(negedge clk);
        checks++; if (out_data !== beat_of(w, 0)) begin errors++; $display("FAIL rstmid_beat0: got %h expected %h", out_data, beat_of(w, 0)); end
        @(negedge clk);
        checks++; if (out_data !== beat_of(w, 1)) begin errors++; $display("FAIL rstmid_beat1: got %h expected %h", out_data, beat_of(w, 1)); end
        @(posedge clk); #1 rst = 1'b1;
        #1;
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld: got %b expected 0", out_vld); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rstmid_last: got %b expected 0", out_last); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 0000", out_data); end
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL rstmid_in_rdy: got %b expected 0", in_rdy); end
        @(posedge clk); #1 rst = 1'b0;
        in_vld = 1'b1; in_data = w2;
        for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), beat_of(w2, k)});
        @(posedge clk); #1 in_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (out_data !== beat_of(w2, k)) begin errors++; $display("FAIL rstmid_new_data[%0d]: got %h expected %h", k, out_data, beat_of(w2, k)); end
            checks++; if (out_last !== (k == 3)) begin errors++; $display("FAIL rstmid_new_last[%0d]: got %b expected %b", k, out_last, (k == 3)); end
        end
        @(negedge clk);
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rstmid_idle_vld: got %b expected 0", out_vld); end
    endtask

    task automatic test_scoreboard();
        int n;
        logic [16:0] e;
        @(posedge clk); #1;
        n = exp_q.size();
        checks++; if (obs_n != n) begin errors++; $display("FAIL sb_count: got %0d beats expected %0d", obs_n, n); end
        for (int i = 0; i < n && i < obs_n; i++) begin
            e = exp_q.pop_front();
            checks++; if (obs_mem[i] !== e) begin errors++; $display("FAIL sb_beat[%0d]: got %h expected %h", i, obs_mem[i], e); end
        end
    endtask

    task automatic test_ratio1();
        localparam int N = 40;
        logic [63:0] exp1_q[$];
        logic [63:0] e;
        int   sent = 0;
        int   got  = 0;
        logic acc  = 1'b0;
        for (int cyc = 0; cyc < 2000 && got < N; cyc++) begin
            @(posedge clk); #1;
            if (acc) begin
                in1_vld = 1'b0;
                sent++;
            end
            if (!in1_vld && sent < N) begin
                in1_vld  = 1'($urandom_range(0, 1));
                in1_data = {$urandom(), $urandom()};
            end
            out1_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            checks++; if (out1_last !== out1_vld) begin errors++; $display("FAIL r1_last_eq_vld[%0d]: got %b expected %b", cyc, out1_last, out1_vld); end
            if (out1_vld && out1_rdy) begin
                got++;
                checks++;
                if (exp1_q.size() == 0) begin
                    errors++; $display("FAIL r1_unexpected[%0d]: got %h expected none", cyc, out1_data);
                end else begin
                    e = exp1_q.pop_front();
                    if (out1_data !== e) begin errors++; $display("FAIL r1_data[%0d]: got %h expected %h", cyc, out1_data, e); end
                end
            end
            acc = in1_vld && in1_rdy;
            if (acc) exp1_q.push_back(in1_data);
        end
        @(posedge clk); #1;
        in1_vld = 1'b0; out1_rdy = 1'b1;
        checks++; if (got != N) begin errors++; $display("FAIL r1_count: got %0d words expected %0d", got, N); end
        checks++; if (exp1_q.size() != 0) begin errors++; $display("FAIL r1_leftover: got %0d expected 0", exp1_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single(64'h4444_3333_2222_1111);
        test_back_to_back(64'hA3A3_A2A2_A1A1_A0A0, 64'hB3B3_B2B2_B1B1_B0B0);
        test_stall(64'h4444_3333_2222_1111);
        test_reset_mid(64'h4444_3333_2222_1111, 64'h8888_7777_6666_5555);
        test_scoreboard();
        test_ratio1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
